// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, streams frame bytes with offsets,
// and issues a per-frame length/error verdict plus good/bad frame counters.
// Optional FCS checking is enabled by defining RX_FCS_CHECK_EN.
`timescale 1ns/1ps
module gmii_rx_framer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic [10:0] out_addr,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned PRE_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PRE_W-1:0] PRE_MAX = '1;
  localparam logic [7:0] PRE_BYTE  = 8'h55;
  localparam logic [7:0] SFD_BYTE  = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_err;

  logic w_sfd_hit;
  logic w_len_ok;
  logic w_fcs_ok;
  logic w_frame_ok;

  // Error-free SFD byte on the line this cycle
  assign w_sfd_hit  = rx_dv && !rx_er && (rxd == SFD_BYTE);
  // Length window on the saturated byte count
  assign w_len_ok   = (32'(r_byte_cnt) >= MIN_LEN) && (32'(r_byte_cnt) <= MAX_LEN);
  assign w_frame_ok = !r_err && w_len_ok && w_fcs_ok;

`ifdef RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  logic [31:0] r_crc;
  logic [31:0] w_crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ CRC_POLY_REF) : (v >> 1);
    end
    return v;
  endfunction

  // Reflected CRC-32 over every DATA byte, seeded when the SFD is accepted
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '0;
    end else if (w_sfd_hit && (r_state == S_IDLE || r_state == S_PREAMBLE)) begin
      r_crc <= '1;
    end else if (r_state == S_DATA && rx_dv) begin
      r_crc <= crc_byte(r_crc, rxd);
    end
  end

  // Residue is quoted in normal bit order; the shift register holds it reflected
  always_comb begin
    w_crc_rev = '0;
    for (int i = 0; i < 32; i++) begin
      w_crc_rev[i] = r_crc[31-i];
    end
  end

  assign w_fcs_ok = (w_crc_rev == CRC_RESIDUE);
`else
  assign w_fcs_ok = 1'b1;
`endif

  // Framing FSM with registered stream, verdict and counter outputs
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pre_cnt  <= '0;
      r_byte_cnt <= '0;
      r_err      <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_addr   <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      cnt_ok     <= '0;
      cnt_err    <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      unique case (r_state)
        S_IDLE: begin
          r_pre_cnt <= '0;
          if (rx_er) begin
            r_state <= S_DROP;
          end else if (rx_dv) begin
            if (rxd == PRE_BYTE) begin
              r_state   <= S_PREAMBLE;
              r_pre_cnt <= PRE_W'(1);
            end else if (w_sfd_hit) begin
              r_state    <= S_DATA;
              r_byte_cnt <= '0;
              r_err      <= 1'b0;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_PREAMBLE: begin
          if (!rx_dv) begin
            r_state <= S_IDLE;
          end else if (rx_er) begin
            r_state <= S_DROP;
          end else if (rxd == PRE_BYTE) begin
            // A 16th preamble byte exceeds the allowed run
            if (r_pre_cnt == PRE_MAX) r_state <= S_DROP;
            else                      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
          end else if (w_sfd_hit) begin
            r_state    <= S_DATA;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            if (rx_er) r_err <= 1'b1;
            if (r_byte_cnt != CNT_MAX) begin
              out_valid  <= 1'b1;
              out_data   <= rxd;
              out_addr   <= r_byte_cnt;
              out_sof    <= (r_byte_cnt == '0);
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end else begin
            r_state    <= S_IDLE;
            frame_done <= 1'b1;
            frame_ok   <= w_frame_ok;
            frame_len  <= r_byte_cnt;
            if (w_frame_ok) cnt_ok  <= cnt_ok + 16'd1;
            else            cnt_err <= cnt_err + 16'd1;
          end
        end
        S_DROP: begin
          if (!rx_dv) begin
            r_state <= S_IDLE;
            cnt_err <= cnt_err + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
